// File: rtl/riscv_pkg.sv
// Shared load/store definitions: FSM states, funct3 codes, access sizes and
// the default bus timeout used by the load/store unit.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // fun3[1:0]=11 has no defined size; it is handled as a word.
    function automatic mem_size_e size_from_fun3(input logic [1:0] sz);
        case (sz)
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    // Byte-lane strobe for an access at lane 0, before shifting by offset.
    function automatic logic [3:0] base_strobe(input mem_size_e size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load aligner: shifts the addressed bytes of a read word down
// to lane 0 and sign- or zero-extends them to 32 bits. No state, so it can be
// shared with a future cache read path.
module load_align_ext
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Align the selected lanes to bit 0, then extend according to size.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        shifted = rdata >> {offset, 3'b000};
        result  = shifted;
        unique case (size)
            SIZE_BYTE: result = {{24{~is_unsigned & shifted[7]}},  shifted[7:0]};
            SIZE_HALF: result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:   result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit: turns one decoded memory instruction into a single
// word-aligned valid/ready bus request, waits for load data, aligns/extends
// it and stalls the pipeline until the access retires. Accesses that sit in
// REQ+WAIT_RSP for TIMEOUT_CYCLES are aborted with bus_err.
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (no bus request, bus_err with the retire pulse); without it the offending
// low address bits are dropped and the access proceeds aligned down.
module lsu_mem_access
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              store,
    input  logic [2:0]        fun3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              access_done,
    output logic [31:0]       load_data,
    output logic              bus_err,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [3:0]        req_wstrb,
    output logic [31:0]       req_wdata,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_rdata
);

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

    lsu_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [3:0]        req_wstrb_q, req_wstrb_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic [1:0]        off_q, off_d;
    mem_size_e         size_q, size_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [31:0]       load_data_q, load_data_d;

    mem_size_e         in_size;
    logic [1:0]        in_off;
    logic [31:0]       ext_data;
    logic              expired;

`ifdef MISALIGN_TRAP_EN
    logic addr_misaligned;
    assign addr_misaligned = ((in_size == SIZE_HALF) && addr[0]) ||
                             ((in_size == SIZE_WORD) && (addr[1:0] != 2'b00));
`endif

    // Decode size and the lane offset actually used, dropping misaligned low bits.
    always_comb begin
        in_size = size_from_fun3(fun3[1:0]);
        in_off  = addr[1:0];
        unique case (in_size)
            SIZE_HALF: in_off = {addr[1], 1'b0};
            SIZE_WORD: in_off = 2'b00;
            default:   in_off = addr[1:0];
        endcase
    end

    load_align_ext u_align (
        .rdata       (rsp_rdata),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

    assign expired = ({1'b0, cnt_q} + 9'd1) >= TIMEOUT_LIM;

    // Next-state and datapath update for the access FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wstrb_d = req_wstrb_q;
        req_wdata_d = req_wdata_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        err_d       = err_q;
        load_data_d = load_data_q;
        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (load || store) begin
                    // A store wins if both are asserted; the load is dropped.
                    req_we_d    = store;
                    req_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    req_wstrb_d = base_strobe(in_size) << in_off;
                    req_wdata_d = wdata << {in_off, 3'b000};
                    off_d       = in_off;
                    size_d      = in_size;
                    uns_d       = fun3[2];
                    cnt_d       = 8'd0;
                    state_d     = REQ;
`ifdef MISALIGN_TRAP_EN
                    if (addr_misaligned) begin
                        state_d     = DONE;
                        err_d       = 1'b1;
                        load_data_d = 32'd0;
                    end
`endif
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (req_ready) begin
                    if (req_we_q) begin
                        state_d     = DONE;
                        load_data_d = 32'd0;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end else if (expired) begin
                    state_d     = DONE;
                    err_d       = 1'b1;
                    load_data_d = 32'd0;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + 8'd1;
                if (rsp_valid) begin
                    state_d     = DONE;
                    load_data_d = ext_data;
                end else if (expired) begin
                    state_d     = DONE;
                    err_d       = 1'b1;
                    load_data_d = 32'd0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wstrb_q <= 4'd0;
            req_wdata_q <= 32'd0;
            off_q       <= 2'd0;
            size_q      <= SIZE_BYTE;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wstrb_q <= req_wstrb_d;
            req_wdata_q <= req_wdata_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
        end
    end

    assign req_valid   = (state_q == REQ);
    assign access_done = (state_q == DONE);
    assign bus_err     = (state_q == DONE) && err_q;
    assign stall       = (load || store) && (state_q != DONE);
    assign req_we      = req_we_q;
    assign req_addr    = req_addr_q;
    assign req_wstrb   = req_wstrb_q;
    assign req_wdata   = req_wdata_q;
    assign load_data   = load_data_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Self-checking bench for lsu_mem_access: vector table with a scoreboard
// queue of expected load results, plus hand-written multi-cycle sequences.
// A second instance with an 8-cycle timeout and a never-ready bus covers abort.
module tb_lsu_mem_access;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, store;
    logic [2:0]  fun3;
    logic [31:0] addr, wdata;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_rdata;

    logic        stall, access_done, bus_err, req_valid, req_we;
    logic [31:0] load_data, req_addr, req_wdata;
    logic [3:0]  req_wstrb;

    logic        to_stall, to_done, to_err, to_req_valid, to_req_we;
    logic [31:0] to_load_data, to_req_addr, to_req_wdata;
    logic [3:0]  to_req_wstrb;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    lsu_mem_access #(.TIMEOUT_CYCLES(255), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst), .load(load), .store(store), .fun3(fun3),
        .addr(addr), .wdata(wdata), .stall(stall), .access_done(access_done),
        .load_data(load_data), .bus_err(bus_err), .req_valid(req_valid),
        .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata)
    );

    lsu_mem_access #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) u_to (
        .clk(clk), .rst(rst), .load(load), .store(store), .fun3(fun3),
        .addr(addr), .wdata(wdata), .stall(to_stall), .access_done(to_done),
        .load_data(to_load_data), .bus_err(to_err), .req_valid(to_req_valid),
        .req_ready(1'b0), .req_we(to_req_we), .req_addr(to_req_addr),
        .req_wstrb(to_req_wstrb), .req_wdata(to_req_wdata), .rsp_valid(1'b0),
        .rsp_rdata(32'h0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pop the oldest expected load result and compare it with the DUT output.
    task automatic pop_check(input string name, input logic [31:0] act);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_unexpected_retire"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic [31:0] ea,
                                input logic [3:0] es, input logic [31:0] ew,
                                input logic [31:0] el);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.exp_addr = ea; v.exp_wstrb = es; v.exp_wdata = ew; v.exp_load = el;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; store = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One access with an always-ready bus and a response one cycle after the handshake.
    task automatic run_vec(input vec_t v, input int idx);
        int  cyc = 0;
        int  hs = 0;
        bit  done = 1'b0;
        bit  hs_now;
        int  exp_cyc;
        exp_cyc = v.st ? 3 : 4;
        @(posedge clk); #1;
        load = v.ld; store = v.st; fun3 = v.f3; addr = v.addr; wdata = v.wdata;
        req_ready = 1'b1; rsp_valid = 1'b0; rsp_rdata = 32'hBAD0BAD0;
        exp_q.push_back(v.exp_load);
        while (!done && cyc < 20) begin
            cyc++;
            @(negedge clk);
            hs_now = req_valid && req_ready;
            check($sformatf("v%0d_stall_c%0d", idx, cyc), stall, access_done ? 32'd0 : 32'd1);
            if (hs_now) begin
                hs++;
                check($sformatf("v%0d_req_addr", idx), req_addr, v.exp_addr);
                check($sformatf("v%0d_req_we", idx), req_we, v.st);
                if (v.st) begin
                    check($sformatf("v%0d_req_wstrb", idx), req_wstrb, v.exp_wstrb);
                    check($sformatf("v%0d_req_wdata", idx), req_wdata, v.exp_wdata);
                end
            end
            if (access_done) begin
                done = 1'b1;
                check($sformatf("v%0d_done_cycle", idx), cyc, exp_cyc);
                check($sformatf("v%0d_bus_err", idx), bus_err, 32'd0);
                pop_check($sformatf("v%0d_load_data", idx), load_data);
            end
            @(posedge clk); #1;
            rsp_valid = hs_now && !v.st;
            rsp_rdata = rsp_valid ? v.rdata : 32'hBAD0BAD0;
        end
        check($sformatf("v%0d_handshakes", idx), hs, 32'd1);
        check($sformatf("v%0d_retired", idx), done, 32'd1);
        load = 1'b0; store = 1'b0; rsp_valid = 1'b0;
    endtask

    // LW with req_ready low for 5 REQ cycles and the response 3 cycles after the handshake.
    task automatic slow_load();
        int hs = 0;
        int dn = 0;
        int dn_cyc = 0;
        @(posedge clk); #1;
        load = 1'b1; store = 1'b0; fun3 = F3_LW; addr = 32'h10C; wdata = 32'h0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'hBAD0BAD0;
        exp_q.push_back(32'h13579BDF);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            check($sformatf("slow_req_valid_c%0d", cyc), req_valid, (cyc >= 2 && cyc <= 7));
            if (req_valid) begin
                check($sformatf("slow_req_addr_c%0d", cyc), req_addr, 32'h10C);
                check($sformatf("slow_req_we_c%0d", cyc), req_we, 32'd0);
            end
            if (req_valid && req_ready) hs++;
            if (access_done) begin
                dn++;
                dn_cyc = cyc;
                pop_check("slow_load_data", load_data);
            end
            @(posedge clk); #1;
            req_ready = (cyc + 1 == 7);
            rsp_valid = (cyc + 1 == 7) || (cyc + 1 == 10);
            rsp_rdata = (cyc + 1 == 10) ? 32'h13579BDF : 32'hBAD0BAD0;
            if (cyc + 1 >= 12) load = 1'b0;
        end
        check("slow_handshakes", hs, 32'd1);
        check("slow_done_count", dn, 32'd1);
        check("slow_done_cycle", dn_cyc, 32'd11);
        req_ready = 1'b0; rsp_valid = 1'b0;
    endtask

    // Never-ready bus on the 8-cycle instance: abort after 8 REQ cycles.
    task automatic timeout_seq();
        do_reset();
        load = 1'b1; store = 1'b0; fun3 = F3_LW; addr = 32'h40; req_ready = 1'b0;
        exp_q.push_back(32'h0);
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(negedge clk);
            check($sformatf("to_req_valid_c%0d", cyc), to_req_valid, (cyc >= 2 && cyc <= 9));
            check($sformatf("to_done_c%0d", cyc), to_done, (cyc == 10));
            check($sformatf("to_bus_err_c%0d", cyc), to_err, (cyc == 10));
            if (to_done) pop_check("to_load_data", to_load_data);
            @(posedge clk); #1;
            if (cyc + 1 >= 11) load = 1'b0;
        end
        check("to_idle_stall", to_stall, 32'd0);
    endtask

    // Reset while waiting for the response; a late rsp_valid must be dropped.
    task automatic reset_mid_access();
        run_vec(mk(1'b1, 1'b0, F3_LW, 32'h100, 32'h0, 32'h600DF00D,
                   32'h100, 4'b1111, 32'h0, 32'h600DF00D), 100);
        @(posedge clk); #1;
        load = 1'b1; store = 1'b0; fun3 = F3_LW; addr = 32'h80; req_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid_handshake", req_valid && req_ready, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; load = 1'b0; req_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hFFFFFFFF;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            check($sformatf("rstmid_req_valid_%0d", cyc), req_valid, 32'd0);
            check($sformatf("rstmid_done_%0d", cyc), access_done, 32'd0);
            check($sformatf("rstmid_bus_err_%0d", cyc), bus_err, 32'd0);
            check($sformatf("rstmid_load_data_%0d", cyc), load_data, 32'd0);
            check($sformatf("rstmid_req_addr_%0d", cyc), req_addr, 32'd0);
            check($sformatf("rstmid_req_wstrb_%0d", cyc), req_wstrb, 32'd0);
            check($sformatf("rstmid_req_wdata_%0d", cyc), req_wdata, 32'd0);
            check($sformatf("rstmid_req_we_%0d", cyc), req_we, 32'd0);
            @(posedge clk); #1;
            rsp_valid = (cyc == 0);
        end
        rsp_valid = 1'b0;
    endtask

`ifdef MISALIGN_TRAP_EN
    // Misaligned LW: no bus request, bus_err with the retire pulse on cycle 2.
    task automatic misalign_seq();
        @(posedge clk); #1;
        load = 1'b1; store = 1'b0; fun3 = F3_LW; addr = 32'h101; req_ready = 1'b1;
        exp_q.push_back(32'h0);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            check($sformatf("mis_req_valid_c%0d", cyc), req_valid, 32'd0);
            check($sformatf("mis_done_c%0d", cyc), access_done, (cyc == 2));
            check($sformatf("mis_bus_err_c%0d", cyc), bus_err, (cyc == 2));
            if (access_done) pop_check("mis_load_data", load_data);
            @(posedge clk); #1;
            if (cyc + 1 >= 3) load = 1'b0;
        end
    endtask
`endif

    initial begin
        rst = 1'b1; load = 1'b0; store = 1'b0; fun3 = 3'b000; addr = 32'h0;
        wdata = 32'h0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;

        //       ld    st    f3      addr       wdata         rdata         exp_addr  strb     exp_wdata     exp_load
        vecs.push_back(mk(1'b0, 1'b1, F3_SW,  32'h104, 32'hDEADBEEF, 32'h0,        32'h104, 4'b1111, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, F3_SB,  32'h203, 32'h000000A5, 32'h0,        32'h200, 4'b1000, 32'hA5000000, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, F3_SH,  32'h102, 32'h1234BEEF, 32'h0,        32'h100, 4'b1100, 32'hBEEF0000, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, F3_LB,  32'h102, 32'h0,        32'h12F03456, 32'h100, 4'b0000, 32'h0,        32'hFFFFFFF0));
        vecs.push_back(mk(1'b1, 1'b0, F3_LBU, 32'h102, 32'h0,        32'h12F03456, 32'h100, 4'b0000, 32'h0,        32'h000000F0));
        vecs.push_back(mk(1'b1, 1'b0, F3_LH,  32'h102, 32'h0,        32'h12F03456, 32'h100, 4'b0000, 32'h0,        32'h000012F0));
        vecs.push_back(mk(1'b1, 1'b0, F3_LHU, 32'h100, 32'h0,        32'h00008001, 32'h100, 4'b0000, 32'h0,        32'h00008001));
        vecs.push_back(mk(1'b1, 1'b0, F3_LH,  32'h100, 32'h0,        32'h00008001, 32'h100, 4'b0000, 32'h0,        32'hFFFF8001));
        vecs.push_back(mk(1'b1, 1'b0, F3_LB,  32'h103, 32'h0,        32'h80000000, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80));
        vecs.push_back(mk(1'b1, 1'b0, F3_LW,  32'h100, 32'h0,        32'hCAFEF00D, 32'h100, 4'b0000, 32'h0,        32'hCAFEF00D));
        vecs.push_back(mk(1'b1, 1'b1, F3_SW,  32'h010, 32'h11223344, 32'h0,        32'h010, 4'b1111, 32'h11223344, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b011, 32'h020, 32'h55667788, 32'h0,        32'h020, 4'b1111, 32'h55667788, 32'h0));
`ifndef MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 1'b1, F3_SH,  32'h101, 32'h0000ABCD, 32'h0,        32'h100, 4'b0011, 32'h0000ABCD, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, F3_LW,  32'h103, 32'h0,        32'h0BADF00D, 32'h100, 4'b0000, 32'h0,        32'h0BADF00D));
        vecs.push_back(mk(1'b1, 1'b0, F3_LH,  32'h103, 32'h0,        32'hA1B2C3D4, 32'h100, 4'b0000, 32'h0,        32'hFFFFA1B2));
`endif

        do_reset();
        @(negedge clk);
        check("rst_req_valid", req_valid, 32'd0);
        check("rst_req_we", req_we, 32'd0);
        check("rst_done", access_done, 32'd0);
        check("rst_bus_err", bus_err, 32'd0);
        check("rst_req_addr", req_addr, 32'd0);
        check("rst_req_wstrb", req_wstrb, 32'd0);
        check("rst_req_wdata", req_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_stall", stall, 32'd0);
        check("rst_to_req_valid", to_req_valid, 32'd0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        slow_load();
        reset_mid_access();
        timeout_seq();
`ifdef MISALIGN_TRAP_EN
        do_reset();
        misalign_seq();
`endif

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
